// File: rtl/ps2_host_tx_ctrl.sv
// PS/2 host-to-device transmit sequencer: request-to-send, bit shifting on
// device clock falling edges, ACK check and transfer timeout.
module ps2_host_tx_ctrl #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int REQ_CYCLES     = 100,
  parameter int TIMEOUT_CYCLES = 750000,
  parameter int CNT_W          = 20
) (
  input  logic       CLK_50M,
  input  logic       rst_n,
  input  logic       send,
  input  logic [7:0] tx_data,
  output logic       ready,
  output logic       done,
  output logic [1:0] status,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_REQ, S_TX, S_WAIT_ACK, S_WAIT_IDLE, S_DONE
  } state_e;

  localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] REQ_LAST = CNT_W'(REQ_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e           state_q, state_d;
  logic [9:0]       frame_q, frame_d;
  logic [3:0]       bit_idx_q, bit_idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             clk_oe_q, clk_oe_d;
  logic             data_oe_q, data_oe_d;
  logic [1:0]       status_q, status_d;

  // Synchronizers reset high (idle bus level) so reset release never fakes an edge.
  logic [1:0] clk_sync_q, data_sync_q;
  logic       clk_prev_q;
  logic       clk_s, data_s, fe;

  assign clk_s  = clk_sync_q[1];
  assign data_s = data_sync_q[1];
  assign fe     = clk_prev_q & ~clk_s;

  always_ff @(posedge CLK_50M or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
      clk_prev_q  <= 1'b1;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], ps2_clk_in};
      data_sync_q <= {data_sync_q[0], ps2_data_in};
      clk_prev_q  <= clk_s;
    end
  end

  always_ff @(posedge CLK_50M or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      frame_q   <= '0;
      bit_idx_q <= '0;
      cnt_q     <= '0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
      status_q  <= 2'b00;
    end else begin
      state_q   <= state_d;
      frame_q   <= frame_d;
      bit_idx_q <= bit_idx_d;
      cnt_q     <= cnt_d;
      clk_oe_q  <= clk_oe_d;
      data_oe_q <= data_oe_d;
      status_q  <= status_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    frame_d   = frame_q;
    bit_idx_d = bit_idx_q;
    cnt_d     = cnt_q;
    clk_oe_d  = clk_oe_q;
    data_oe_d = data_oe_q;
    status_d  = status_q;
    unique case (state_q)
      S_IDLE: begin
        if (send) begin
          frame_d   = {1'b1, ~^tx_data, tx_data};
          status_d  = 2'b00;
          cnt_d     = '0;
          bit_idx_d = '0;
          clk_oe_d  = 1'b1;
          data_oe_d = 1'b0;
          state_d   = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        if (cnt_q == INH_LAST) begin
          cnt_d     = '0;
          data_oe_d = 1'b1;
          state_d   = S_REQ;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_REQ: begin
        if (cnt_q == REQ_LAST) begin
          cnt_d    = '0;
          clk_oe_d = 1'b0;
          state_d  = S_TX;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_TX, S_WAIT_ACK, S_WAIT_IDLE: begin
        cnt_d = cnt_q + 1'b1;
        // Timeout wins over an edge arriving on the same cycle.
        if (cnt_q == TO_LAST) begin
          clk_oe_d  = 1'b0;
          data_oe_d = 1'b0;
          status_d  = 2'b10;
          state_d   = S_DONE;
        end else if (state_q == S_TX) begin
          if (fe) begin
            data_oe_d = ~frame_q[bit_idx_q];
            bit_idx_d = bit_idx_q + 1'b1;
            if (bit_idx_q == 4'd9) state_d = S_WAIT_ACK;
          end
        end else if (state_q == S_WAIT_ACK) begin
          if (fe) begin
            status_d = data_s ? 2'b01 : 2'b00;
            state_d  = S_WAIT_IDLE;
          end
        end else if (clk_s && data_s) begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign ready       = (state_q == S_IDLE);
  assign done        = (state_q == S_DONE);
  assign status      = status_q;
  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;

endmodule

// File: tb/tb_ps2_host_tx_ctrl.sv
// Bench for ps2_host_tx_ctrl: behavioural PS/2 device on open-drain lines,
// status scoreboard popped on each done pulse.
module tb_ps2_host_tx_ctrl;
  localparam int INH = 50;
  localparam int REQ = 10;
  localparam int TO  = 2000;
  localparam int CW  = 12;
  localparam int HP  = 20;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       send = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       ready, done;
  logic [1:0] status;
  logic       ps2_clk_oe, ps2_data_oe;
  logic       dev_clk = 1'b1, dev_data = 1'b1;
  logic       ps2_clk_in, ps2_data_in;

  // Wired-AND of host pull-down and device drive.
  assign ps2_clk_in  = ~ps2_clk_oe & dev_clk;
  assign ps2_data_in = ~ps2_data_oe & dev_data;

  ps2_host_tx_ctrl #(
    .INHIBIT_CYCLES(INH), .REQ_CYCLES(REQ), .TIMEOUT_CYCLES(TO), .CNT_W(CW)
  ) dut (
    .CLK_50M(clk), .rst_n(rst_n), .send(send), .tx_data(tx_data),
    .ready(ready), .done(done), .status(status),
    .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in),
    .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe)
  );

  always #10 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic [1:0] st;
    string      tag;
  } exp_t;

  exp_t sb[$];
  int   done_cnt = 0;

  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n && done === 1'b1) begin
      done_cnt++;
      if (sb.size() == 0) chk("sb_underflow", 32'd1, 32'd0);
      else begin
        e = sb.pop_front();
        chk({e.tag, "_status"}, 32'(status), 32'(e.st));
        chk({e.tag, "_oe_at_done"}, 32'({ps2_clk_oe, ps2_data_oe}), 32'd0);
      end
    end
  end

  // Device: samples start bit, then d0..d7, parity, stop on rising edges;
  // optionally ACKs on clock 11 or aborts after the low phase of clock stop_k.
  task automatic device(input bit ack, input bit inject, input int stop_k,
                        output logic [10:0] bits);
    bits = '0;
    bits[0] = ps2_data_in;
    repeat (HP) @(posedge clk);
    #1;
    for (int k = 1; k <= 11; k++) begin
      dev_clk = 1'b0;
      if (k == 11 && ack) dev_data = 1'b0;
      if (inject && k == 5) begin
        @(negedge clk); send = 1'b1; tx_data = 8'h55;
        @(negedge clk); send = 1'b0;
      end
      repeat (HP) @(posedge clk);
      #1;
      if (k == stop_k) begin
        dev_clk = 1'b1;
        return;
      end
      if (k <= 10) bits[k] = ps2_data_in;
      dev_clk = 1'b1;
      repeat (HP) @(posedge clk);
      #1;
    end
    dev_data = 1'b1;
  endtask

  // mode: 0 ACK, 1 no ACK, 2 silent device (timeout), 3 reset after fe 4
  task automatic run_xfer(input string tag, input logic [7:0] d, input int mode,
                          input bit inject);
    logic [10:0] bits, expb;
    logic [1:0]  st;
    exp_t        e;
    int n, first, c, dc0;
    expb = {1'b1, ~^d, d, 1'b0};
    st   = (mode == 0) ? 2'b00 : (mode == 1) ? 2'b01 : 2'b10;
    n = 0;
    while (!ready && n < 1000) begin @(posedge clk); #1; n++; end
    chk({tag, "_ready_in"}, 32'(ready), 32'd1);
    dc0 = done_cnt;
    @(negedge clk);
    send = 1'b1; tx_data = d;
    e.st = st; e.tag = tag;
    sb.push_back(e);
    @(posedge clk); #1;
    send = 1'b0;
    chk({tag, "_ready_drop"}, 32'(ready), 32'd0);
    n = 0; first = -1;
    while (ps2_clk_oe && n < INH + REQ + 100) begin
      if (ps2_data_oe && first < 0) first = n;
      n++;
      @(posedge clk); #1;
    end
    chk({tag, "_clk_oe_len"}, n, INH + REQ);
    chk({tag, "_data_oe_rise"}, first, INH);
    if (mode == 3) begin
      device(1'b1, 1'b0, 4, bits);
      rst_n = 1'b0;
      #1;
      chk({tag, "_rst_oe"}, 32'({ps2_clk_oe, ps2_data_oe}), 32'd0);
      chk({tag, "_rst_ready"}, 32'(ready), 32'd1);
      void'(sb.pop_back());
      repeat (5) @(posedge clk);
      @(negedge clk); rst_n = 1'b1;
      repeat (HP * 12) @(posedge clk);
      #1;
      chk({tag, "_no_done"}, done_cnt, dc0);
      return;
    end
    if (mode == 2) begin
      c = 0;
      while (!done && c < TO + 10) begin @(posedge clk); #1; c++; end
      chk({tag, "_to_latency"}, 32'(c == TO || c == TO + 1), 32'd1);
    end else begin
      device(mode == 0, inject, 0, bits);
      chk({tag, "_frame"}, 32'(bits), 32'(expb));
    end
    n = 0;
    while (done_cnt == dc0 && n < 5000) begin @(posedge clk); #1; n++; end
    chk({tag, "_done_seen"}, done_cnt, dc0 + 1);
    chk({tag, "_ready_after"}, 32'(ready), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    chk({tag, "_status_hold"}, 32'(status), 32'(st));
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready",  32'(ready), 32'd1);
    chk("rst_done",   32'(done), 32'd0);
    chk("rst_status", 32'(status), 32'd0);
    chk("rst_oe",     32'({ps2_clk_oe, ps2_data_oe}), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    repeat (5) @(posedge clk);

    run_xfer("f4_ack",     8'hF4, 0, 1'b0);
    run_xfer("ff_ack",     8'hFF, 0, 1'b0);
    run_xfer("00_ack",     8'h00, 0, 1'b0);
    run_xfer("ed_noack",   8'hED, 1, 1'b0);
    run_xfer("11_timeout", 8'h11, 2, 1'b0);
    run_xfer("a5_inject",  8'hA5, 0, 1'b1);
    run_xfer("3c_b2b",     8'h3C, 0, 1'b0);
    run_xfer("96_reset",   8'h96, 3, 1'b0);
    run_xfer("42_clean",   8'h42, 0, 1'b0);

    chk("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
